mips_div: RTL



---
 rtl/mips_div_pkg.sv | 6 +
 rtl/mips_div_step.sv | 20 ++
 rtl/mips_div.sv | 85 ++++++++
 3 files changed

// File: rtl/mips_div_pkg.sv
// mips_div_pkg: shared types and constants for the iterative divider
package mips_div_pkg;
  localparam int DIV_DATA_W = 32;
  localparam int DIV_ITER_W = $clog2(DIV_DATA_W);
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE} div_state_e;
endpackage

// File: rtl/mips_div_step.sv
// mips_div_step: one combinational restoring-division iteration on magnitudes
module mips_div_step import mips_div_pkg::*; #(
  parameter int DATA_WIDTH = DIV_DATA_W
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] dvs_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);
  logic [DATA_WIDTH:0] sh;
  logic [DATA_WIDTH-1:0] nd;
  logic ge;
  assign sh = {rem_i, quo_i[DATA_WIDTH-1]};
  assign ge = sh >= {1'b0, dvs_i};
  // when the trial subtract succeeds the true difference is below the divisor, so W bits suffice
  assign nd = sh[DATA_WIDTH-1:0] - dvs_i;
  assign rem_o = ge ? nd : sh[DATA_WIDTH-1:0];
  assign quo_o = {quo_i[DATA_WIDTH-2:0], ge};
endmodule

// File: rtl/mips_div.sv
// mips_div: fixed-latency radix-2 restoring divider for MIPS DIV/DIVU (quotient->LO, remainder->HI)
module mips_div import mips_div_pkg::*; #(
  parameter int DATA_WIDTH = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start,
  input  logic                  div_signed,
  input  logic [DATA_WIDTH-1:0] div_op_x,
  input  logic [DATA_WIDTH-1:0] div_op_y,
  output logic                  div_busy,
  output logic                  div_done,
  output logic [DATA_WIDTH-1:0] div_quotient,
  output logic [DATA_WIDTH-1:0] div_remainder,
  output logic                  div_by_zero
);
  localparam int CW = $clog2(DATA_WIDTH);
  div_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic sgn_q, xs_q, ys_q;
  logic [DATA_WIDTH-1:0] x_q, ymag_q, rem_q, quo_q, rem_d, quo_d, xmag, ymag;
  assign xmag = (div_signed && div_op_x[DATA_WIDTH-1]) ? -div_op_x : div_op_x;
  assign ymag = (div_signed && div_op_y[DATA_WIDTH-1]) ? -div_op_y : div_op_y;
  mips_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(ymag_q),
    .rem_o(rem_d),
    .quo_o(quo_d)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= DIV_IDLE;
      cnt_q         <= '0;
      sgn_q         <= 1'b0;
      xs_q          <= 1'b0;
      ys_q          <= 1'b0;
      x_q           <= '0;
      ymag_q        <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      div_busy      <= 1'b0;
      div_done      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
      div_by_zero   <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE, DIV_DONE: begin
          div_done <= 1'b0;
          if (div_start) begin
            sgn_q    <= div_signed;
            xs_q     <= div_op_x[DATA_WIDTH-1];
            ys_q     <= div_op_y[DATA_WIDTH-1];
            x_q      <= div_op_x;
            ymag_q   <= ymag;
            rem_q    <= '0;
            quo_q    <= xmag;
            cnt_q    <= CW'(DATA_WIDTH - 1);
            div_busy <= 1'b1;
            state_q  <= DIV_CALC;
          end else begin
            div_busy <= 1'b0;
            state_q  <= DIV_IDLE;
          end
        end
        DIV_CALC: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          cnt_q   <= cnt_q - 1'b1;
          state_q <= (cnt_q == '0) ? DIV_FIX : DIV_CALC;
        end
        DIV_FIX: begin
          // zero divisor is forced so signed cases report the raw dividend and all-ones quotient
          div_by_zero   <= ymag_q == '0;
          div_quotient  <= (ymag_q == '0) ? '1 : ((sgn_q && (xs_q ^ ys_q)) ? -quo_q : quo_q);
          div_remainder <= (ymag_q == '0) ? x_q : ((sgn_q && xs_q) ? -rem_q : rem_q);
          div_busy      <= 1'b0;
          div_done      <= 1'b1;
          state_q       <= DIV_DONE;
        end
      endcase
    end
  end
endmodule
